if_fetch_unit: RTL and testbench

- Instruction-fetch stage that owns the PC and issues 64-bit reads on the memory arbiter's IF read port.
- Extracts the 32-bit instruction from the returned doubleword.
- Hands instruction plus PC to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) from downstream, including discard of a read already in flight.

---
 rtl/if_fetch_unit_pkg.sv | 20 ++
 rtl/if_fetch_unit_inst_align.sv | 15 +
 rtl/if_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Purpose: shared constants, widths and FSM state encoding for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_unit_pkg;

    localparam int          XLEN         = 64;
    localparam int          ADDR_W       = 32;
    localparam int          NPC_ADDR_BUS = ADDR_W;
    localparam logic        TRUE         = 1'b1;
    localparam logic        FALSE        = 1'b0;
    localparam logic [31:0] RESET_PC     = 32'h8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_OUT  = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_fetch_unit_inst_align.sv
// Purpose: selects the 32-bit instruction word from a fetched doubleword using pc[2].
// Latency: purely combinational.
// Backpressure: none.
module if_inst_align
    import if_fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] dword,
    input  logic            sel_hi,
    output logic [31:0]     word
);

    // Upper word holds the instruction at pc[2] = 1 (little-endian doubleword).
    assign word = sel_hi ? dword[63:32] : dword[31:0];

endmodule

// File: rtl/if_fetch_unit.sv
// Purpose: owns the PC, issues doubleword reads to the arbiter and hands instruction+PC to decode.
// Latency: request to decode valid = arbiter latency + 1 cycle; one-cycle bubble after each handshake.
// Backpressure: holds inst_valid_o with stable data until inst_ready_i; no new read while holding.
module if_fetch_unit #(
    parameter int                ADDR_W   = if_fetch_unit_pkg::ADDR_W,
    parameter int                XLEN     = if_fetch_unit_pkg::XLEN,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(if_fetch_unit_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] if_read_addr_o,
    output logic              if_valid_o,
    output logic [7:0]        if_rmask_o,
    input  logic [XLEN-1:0]   if_rdata_i,
    input  logic              if_rdata_valid_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_misalign_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i
);

    import if_fetch_unit_pkg::*;

    if_state_t         state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              drop, drop_n;
    // Low PC bits of a misaligned redirect that arrived while a read was outstanding.
    logic [1:0]        mis_lo, mis_lo_n;

    logic [ADDR_W-1:0] addr_n;
    logic              req_vld_n;
    logic [7:0]        mask_n;
    logic [31:0]       inst_n;
    logic [ADDR_W-1:0] inst_pc_n;
    logic              mis_n;
    logic              inst_vld_n;

    logic [31:0]       fetched_word;
    logic              resp;
    logic              outstanding;

    if_inst_align u_align (
        .dword  (if_rdata_i),
        .sel_hi (pc[2]),
        .word   (fetched_word)
    );

    assign resp        = if_rdata_valid_i & if_valid_o;
    // A read is outstanding when the request is up and its response has not arrived yet.
    assign outstanding = if_valid_o & ~if_rdata_valid_i;

    // Next-state and next-output computation; redirect overrides the per-state result.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        drop_n     = drop;
        mis_lo_n   = mis_lo;
        req_vld_n  = if_valid_o;
        inst_n     = inst_o;
        inst_pc_n  = inst_pc_o;
        mis_n      = inst_misalign_o;
        inst_vld_n = inst_valid_o;

        case (state)
            IF_IDLE: begin
                state_n   = IF_REQ;
                req_vld_n = TRUE;
            end
            IF_REQ: begin
                if (resp) begin
                    if (drop) begin
                        drop_n = FALSE;
                        if (mis_lo != 2'b00) begin
                            // Deferred misaligned redirect: present a nop instead of re-fetching.
                            mis_lo_n   = 2'b00;
                            req_vld_n  = FALSE;
                            inst_n     = NOP_INST;
                            inst_pc_n  = {pc[ADDR_W-1:2], mis_lo};
                            mis_n      = TRUE;
                            inst_vld_n = TRUE;
                            state_n    = IF_OUT;
                        end else begin
                            req_vld_n = TRUE;
                        end
                    end else begin
                        inst_n     = fetched_word;
                        inst_pc_n  = pc;
                        mis_n      = FALSE;
                        inst_vld_n = TRUE;
                        pc_n       = pc + ADDR_W'(4);
                        req_vld_n  = FALSE;
                        state_n    = IF_OUT;
                    end
                end
            end
            IF_OUT: begin
                if (inst_ready_i) begin
                    inst_vld_n = FALSE;
                    req_vld_n  = TRUE;
                    state_n    = IF_REQ;
                end
            end
            default: begin
                state_n   = IF_IDLE;
                req_vld_n = FALSE;
            end
        endcase

        if (redirect_valid_i) begin
            pc_n       = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            inst_vld_n = FALSE;
            if (outstanding) begin
                // Request must stay stable until its response; mark it for discard.
                drop_n    = TRUE;
                mis_lo_n  = redirect_pc_i[1:0];
                req_vld_n = TRUE;
                state_n   = IF_REQ;
            end else begin
                drop_n   = FALSE;
                mis_lo_n = 2'b00;
                if (redirect_pc_i[1:0] != 2'b00) begin
                    req_vld_n  = FALSE;
                    inst_n     = NOP_INST;
                    inst_pc_n  = redirect_pc_i;
                    mis_n      = TRUE;
                    inst_vld_n = TRUE;
                    state_n    = IF_OUT;
                end else begin
                    req_vld_n = TRUE;
                    state_n   = IF_REQ;
                end
            end
        end

        addr_n = (req_vld_n && !outstanding) ? {pc_n[ADDR_W-1:3], 3'b000} : if_read_addr_o;
        mask_n = req_vld_n ? 8'hFF : 8'h00;
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IF_IDLE;
            pc              <= RESET_PC;
            drop            <= FALSE;
            mis_lo          <= 2'b00;
            if_read_addr_o  <= '0;
            if_valid_o      <= FALSE;
            if_rmask_o      <= 8'h00;
            inst_o          <= '0;
            inst_pc_o       <= '0;
            inst_misalign_o <= FALSE;
            inst_valid_o    <= FALSE;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            drop            <= drop_n;
            mis_lo          <= mis_lo_n;
            if_read_addr_o  <= addr_n;
            if_valid_o      <= req_vld_n;
            if_rmask_o      <= mask_n;
            inst_o          <= inst_n;
            inst_pc_o       <= inst_pc_n;
            inst_misalign_o <= mis_n;
            inst_valid_o    <= inst_vld_n;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Purpose: self-checking bench for if_fetch_unit with an arbiter model and an instruction-stream scoreboard.
// Latency: arbiter response latency is varied per request (2..6 cycles).
// Backpressure: decode readiness is driven both directed and randomly.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_read_addr_o;
    logic        if_valid_o;
    logic [7:0]  if_rmask_o;
    logic [63:0] if_rdata_i;
    logic        if_rdata_valid_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_misalign_o;
    logic        inst_valid_o;
    logic        inst_ready_i;

    int n_tests = 0;
    int n_fail  = 0;
    int n_del   = 0;

    // Arbiter model state and the expected PC of the next instruction decode should receive.
    logic        busy;
    logic [31:0] a_addr;
    int          wt;
    int          lat;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .if_read_addr_o   (if_read_addr_o),
        .if_valid_o       (if_valid_o),
        .if_rmask_o       (if_rmask_o),
        .if_rdata_i       (if_rdata_i),
        .if_rdata_valid_i (if_rdata_valid_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_misalign_o  (inst_misalign_o),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i)
    );

    function automatic logic [63:0] mem(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'h0000_0297_0000_0513;
        return {(a * 32'h9E37_79B1) ^ 32'h1234_5678, (a * 32'h85EB_CA6B) + 32'd7};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called at a negedge with this cycle's decode/redirect inputs already set.
    task automatic step();
        logic        hs;
        logic [63:0] d;
        logic [31:0] ew;
        logic        emis;
        if_rdata_valid_i = 1'b0;
        if_rdata_i       = {$urandom, $urandom};
        if (rst) begin
            busy = 1'b0;
        end else if (!busy && if_valid_o) begin
            busy   = 1'b1;
            a_addr = if_read_addr_o;
            wt     = lat - 1;
            check("req_align", {61'd0, a_addr[2:0]}, 64'd0);
        end else if (busy) begin
            check("req_hold_vld", {63'd0, if_valid_o}, 64'd1);
            check("req_hold_addr", {32'd0, if_read_addr_o}, {32'd0, a_addr});
            if (wt <= 1) begin
                if_rdata_valid_i = 1'b1;
                if_rdata_i       = mem(a_addr);
                busy             = 1'b0;
            end else begin
                wt--;
            end
        end
        check("rmask", {56'd0, if_rmask_o}, {56'd0, (if_valid_o ? 8'hFF : 8'h00)});

        hs = !rst && inst_valid_o && inst_ready_i && !redirect_valid_i;
        if (hs) begin
            emis = (exp_pc[1:0] != 2'b00);
            d    = mem({exp_pc[31:3], 3'b000});
            ew   = emis ? NOP : (exp_pc[2] ? d[63:32] : d[31:0]);
            check("del_pc", {32'd0, inst_pc_o}, {32'd0, exp_pc});
            check("del_inst", {32'd0, inst_o}, {32'd0, ew});
            check("del_mis", {63'd0, inst_misalign_o}, {63'd0, emis});
            exp_pc = emis ? {exp_pc[31:2], 2'b00} : exp_pc + 32'd4;
            n_del++;
        end
        if (!rst && redirect_valid_i) exp_pc = redirect_pc_i;
        if (rst) exp_pc = RST_PC;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_del(input int target, input int budget);
        for (int i = 0; i < budget && n_del < target; i++) step();
        check("deliver_timeout", {63'd0, (n_del >= target)}, 64'd1);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !inst_valid_o; i++) step();
        check("valid_timeout", {63'd0, inst_valid_o}, 64'd1);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = tgt;
        step();
        redirect_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, {32'd0, if_read_addr_o}, 64'd0);
        check({tag, "_vld"}, {63'd0, if_valid_o}, 64'd0);
        check({tag, "_mask"}, {56'd0, if_rmask_o}, 64'd0);
        check({tag, "_inst"}, {32'd0, inst_o}, 64'd0);
        check({tag, "_ipc"}, {32'd0, inst_pc_o}, 64'd0);
        check({tag, "_mis"}, {63'd0, inst_misalign_o}, 64'd0);
        check({tag, "_ivld"}, {63'd0, inst_valid_o}, 64'd0);
    endtask

    initial begin
        logic [31:0] h_inst;
        logic [31:0] h_pc;
        logic [31:0] tgt;
        int          d0;

        rst = 1'b1; inst_ready_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        if_rdata_i = '0; if_rdata_valid_i = 1'b0;
        busy = 1'b0; a_addr = '0; wt = 0; lat = 2; exp_pc = RST_PC;
        @(negedge clk);
        repeat (3) step();
        check_reset_outputs("reset");

        // Reset release, latency 2, first two instructions from one doubleword.
        rst = 1'b0; inst_ready_i = 1'b1;
        step();
        check("first_req_vld", {63'd0, if_valid_o}, 64'd1);
        check("first_req_addr", {32'd0, if_read_addr_o}, 64'h8000_0000);
        check("first_req_mask", {56'd0, if_rmask_o}, 64'hFF);
        wait_del(1, 20);
        check("second_req_vld", {63'd0, if_valid_o}, 64'd1);
        check("second_req_addr", {32'd0, if_read_addr_o}, 64'h8000_0000);
        wait_del(2, 20);
        check("third_req_addr", {32'd0, if_read_addr_o}, 64'h8000_0008);

        // Redirect while the read to 0x8000_0008 is outstanding (latency 4).
        lat = 4;
        step();
        redirect(32'h8000_0100);
        for (int i = 0; i < 10 && if_read_addr_o != 32'h8000_0100; i++) begin
            check("redir_hold_addr", {32'd0, if_read_addr_o}, 64'h8000_0008);
            step();
        end
        check("redir_new_addr", {32'd0, if_read_addr_o}, 64'h8000_0100);
        lat = 2;
        wait_del(3, 20);

        // Backpressure: five cycles of not-ready.
        inst_ready_i = 1'b0;
        wait_valid(20);
        h_inst = inst_o; h_pc = inst_pc_o;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {63'd0, inst_valid_o}, 64'd1);
            check("bp_inst", {32'd0, inst_o}, {32'd0, h_inst});
            check("bp_pc", {32'd0, inst_pc_o}, {32'd0, h_pc});
            check("bp_no_req", {63'd0, if_valid_o}, 64'd0);
        end
        inst_ready_i = 1'b1;
        d0 = n_del;
        step();
        check("bp_delivered", {32'd0, n_del}, {32'd0, d0 + 1});
        check("bp_req_after_hs", {63'd0, if_valid_o}, 64'd1);

        // Redirect coincident with a handshake in OUT: that instruction is dropped.
        inst_ready_i = 1'b0;
        wait_valid(20);
        inst_ready_i = 1'b1;
        d0 = n_del;
        redirect(32'h8000_0200);
        check("redir_out_vld", {63'd0, inst_valid_o}, 64'd0);
        wait_del(d0 + 1, 20);

        // Misaligned redirect target: nop with misalign flag, no read issued.
        inst_ready_i = 1'b0;
        wait_valid(20);
        redirect(32'h8000_0102);
        check("mis_vld", {63'd0, inst_valid_o}, 64'd1);
        check("mis_flag", {63'd0, inst_misalign_o}, 64'd1);
        check("mis_inst", {32'd0, inst_o}, {32'd0, NOP});
        check("mis_pc", {32'd0, inst_pc_o}, 64'h8000_0102);
        for (int i = 0; i < 3; i++) begin
            check("mis_no_req", {63'd0, if_valid_o}, 64'd0);
            step();
        end
        inst_ready_i = 1'b1;
        wait_del(n_del + 2, 30);

        // PC wrap across the top of the address space.
        d0 = n_del;
        redirect(32'hFFFF_FFF8);
        wait_del(d0 + 3, 40);

        // Randomized readiness, latency and redirects (some misaligned).
        d0 = n_del;
        for (int i = 0; i < 1500; i++) begin
            lat          = $urandom_range(2, 6);
            inst_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                tgt = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
                if ($urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
                redirect(tgt);
            end else begin
                step();
            end
        end
        check("rand_progress", {63'd0, (n_del > d0 + 50)}, 64'd1);

        // Reset in the middle of an outstanding read.
        inst_ready_i = 1'b1; lat = 5;
        for (int i = 0; i < 20 && !(busy && if_valid_o); i++) step();
        check("rst_mid_req", {63'd0, (busy && if_valid_o)}, 64'd1);
        rst = 1'b1;
        step();
        check_reset_outputs("mid_rst");
        rst = 1'b0; lat = 2;
        step();
        check("restart_vld", {63'd0, if_valid_o}, 64'd1);
        check("restart_addr", {32'd0, if_read_addr_o}, 64'h8000_0000);
        wait_del(n_del + 2, 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
